sev_seg_capture: RTL and testbench
==================================

SEV_SEG_CAPTURE -- requirements
Module: sev_seg_capture

Interface
REQ-001 Parameter NUM_DIG, default 6: number of multiplexed digits in one frame (hh:mm:ss).
REQ-002 Parameter STABLE_CYC, default 4, range 1..255: number of stable cycles required before a pattern is accepted.
REQ-003 Port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-004 Port rst_n, input, 1: synchronous, active-low reset.
REQ-005 Port dig_sel, input, NUM_DIG: one-hot active-high digit enable from the display scanner; all-zero means blanking.
REQ-006 Port ss_val, input, 7: segment pattern, bit0 = a ... bit6 = g, active-low (0 = lit).
REQ-007 Port err_clr, input, 1: clears the sticky error flags.
REQ-008 Port dig_val, output, 4*NUM_DIG: last complete decoded frame; nibble i belongs to dig_sel[i].
REQ-009 Port frame_vld, output, 1: one-cycle pulse when dig_val updates.
REQ-010 Port err_pat, output, 1: sticky flag; a stable pattern was not a legal hex glyph.
REQ-011 Port err_sel, output, 1: sticky flag; a stable dig_sel had more than one bit set.

Function
REQ-012 Encode table, value 0..F to ss_val hex: 40 79 24 30 19 12 02 78 00 10 08 03 46 21 06 0E (exact inverse of sev_seg_dec); any other pattern is illegal.
REQ-013 Inputs are registered into s_sel/s_seg every cycle; all decisions use the registered copies.
REQ-014 Stability counter behaviour:
- Cleared to 0 when the incoming {dig_sel, ss_val} differs from {s_sel, s_seg}.
- Otherwise increments, saturating at STABLE_CYC.
REQ-015 Capture FSM states: WAIT (count < STABLE_CYC) and HELD (pattern already acted on).
- WAIT to HELD on the edge the count reaches STABLE_CYC; this is the capture edge.
- HELD to WAIT on any input change.
- Exactly one capture per stable period.
REQ-016 Acceptance window: a pattern presented on STABLE_CYC+1 consecutive rising edges is captured; one presented on STABLE_CYC edges is not.
REQ-017 Capture action by s_sel:
- One-hot with a legal s_seg: write the nibble into shadow slot i and set seen[i].
- One-hot with an illegal s_seg: set err_pat; shadow and seen are unchanged.
- All-zero: no action.
- Multi-hot: set err_sel; no write.
REQ-018 A repeated capture of an already-seen digit overwrites its shadow nibble (newest value wins).
REQ-019 Frame completion: when seen becomes all-ones at a capture edge, on the next edge:
- dig_val is loaded from the shadow registers;
- frame_vld goes high for exactly 1 cycle;
- seen is cleared.
REQ-020 dig_val holds its value between frames and never shows a partial frame.
REQ-021 err_clr clears both sticky flags on the next edge; if a new error is detected on the same edge, the error wins.
REQ-022 Order of digit arrival is irrelevant; the scan may be any permutation, and blank gaps are allowed.

Reset
REQ-023 While rst_n is low at an edge, the following are cleared on that edge:
- dig_val = 0, frame_vld = 0, err_pat = 0, err_sel = 0;
- seen = 0, shadow = 0, counter = 0, s_sel = 0, s_seg = 7F;
- FSM = WAIT.
REQ-024 A reset asserted mid-frame discards all partial captures; the first frame after reset requires all NUM_DIG digits afresh.

Verification
REQ-025 Full frame (NUM_DIG=6, STABLE_CYC=4): scan digits 0..5 with patterns for 1,2,3,4,5,9, each held 6 cycles -> one frame_vld pulse, dig_val = 24'h954321.
REQ-026 Stability boundary: a digit held exactly 4 edges is not captured (no frame); the same digit held 5 edges is captured.
REQ-027 Illegal pattern: ss_val = 7F (blank glyph) on dig_sel = 000001, held 6 cycles -> err_pat = 1, seen[0] not set; err_clr pulse -> err_pat = 0 next cycle.
REQ-028 Multi-hot: dig_sel = 000011 held 6 cycles -> err_sel = 1, no shadow write; then err_clr coinciding with a new multi-hot capture -> err_sel stays 1.
REQ-029 Reset mid-frame: capture 3 digits, pulse rst_n low 1 cycle -> all outputs 0; a following full scan yields exactly one frame_vld with new values.
REQ-030 Sweep: all 16 legal glyphs on digit 0 plus 5 fixed digits -> dig_val[3:0] matches 0..F in each frame; frame_vld pulse width is always 1.

Source files
------------

// File: rtl/sev_seg_capture.sv
`default_nettype none
// ============================================================================
// sev_seg_capture : samples a multiplexed 7-segment drive and rebuilds the
//                   displayed hex frame once every digit has been seen stable.
// Revision        : 1.0
// ============================================================================
module sev_seg_capture #(
  parameter int NUM_DIG    = 6,
  parameter int STABLE_CYC = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_DIG-1:0]   dig_sel,
  input  logic [6:0]           ss_val,
  input  logic                 err_clr,
  output logic [4*NUM_DIG-1:0] dig_val,
  output logic                 frame_vld,
  output logic                 err_pat,
  output logic                 err_sel
);

  localparam logic [7:0]         C_STABLE = 8'(STABLE_CYC);
  localparam logic [NUM_DIG-1:0] C_ALL    = {NUM_DIG{1'b1}};
  localparam logic [6:0]         C_BLANK  = 7'h7F;

  typedef enum logic [0:0] {
    ST_WAIT = 1'b0,
    ST_HELD = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [NUM_DIG-1:0]   s_sel_q, s_sel_d;
  logic [6:0]           s_seg_q, s_seg_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [NUM_DIG-1:0]   seen_q, seen_d;
  logic [4*NUM_DIG-1:0] shadow_q, shadow_d;
  logic [4*NUM_DIG-1:0] dig_val_q, dig_val_d;
  logic                 frame_vld_q, frame_vld_d;
  logic                 err_pat_q, err_pat_d;
  logic                 err_sel_q, err_sel_d;

  logic                 in_chg;
  logic                 capture;
  logic                 sel_onehot;
  logic                 sel_multi;
  logic                 seg_legal;
  logic [3:0]           seg_nib;

  // Glyph decoder on the registered pattern (active-low segments, bit0 = a).
  always_comb begin
    seg_legal = 1'b1;
    seg_nib   = 4'h0;
    case (s_seg_q)
      7'h40: seg_nib = 4'h0;
      7'h79: seg_nib = 4'h1;
      7'h24: seg_nib = 4'h2;
      7'h30: seg_nib = 4'h3;
      7'h19: seg_nib = 4'h4;
      7'h12: seg_nib = 4'h5;
      7'h02: seg_nib = 4'h6;
      7'h78: seg_nib = 4'h7;
      7'h00: seg_nib = 4'h8;
      7'h10: seg_nib = 4'h9;
      7'h08: seg_nib = 4'hA;
      7'h03: seg_nib = 4'hB;
      7'h46: seg_nib = 4'hC;
      7'h21: seg_nib = 4'hD;
      7'h06: seg_nib = 4'hE;
      7'h0E: seg_nib = 4'hF;
      default: seg_legal = 1'b0;
    endcase
  end

  always_comb begin
    sel_onehot = ($countones(s_sel_q) == 1);
    sel_multi  = ($countones(s_sel_q) > 1);
  end

  // Stability counter and capture FSM: one capture per stable period.
  always_comb begin
    s_sel_d = dig_sel;
    s_seg_d = ss_val;
    in_chg  = ({dig_sel, ss_val} != {s_sel_q, s_seg_q});

    if (in_chg) begin
      cnt_d = 8'd0;
    end else if (cnt_q == C_STABLE) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end

    capture = (state_q == ST_WAIT) && (cnt_d == C_STABLE);

    state_d = state_q;
    if (in_chg) begin
      state_d = ST_WAIT;
    end else if (capture) begin
      state_d = ST_HELD;
    end
  end

  // Shadow slots collect digits; the frame is published the edge after the
  // last missing digit arrives, so dig_val never shows a partial frame.
  always_comb begin
    seen_d      = seen_q;
    shadow_d    = shadow_q;
    dig_val_d   = dig_val_q;
    frame_vld_d = 1'b0;

    if (seen_q == C_ALL) begin
      dig_val_d   = shadow_q;
      frame_vld_d = 1'b1;
      seen_d      = '0;
    end

    if (capture && sel_onehot && seg_legal) begin
      for (int i = 0; i < NUM_DIG; i++) begin
        if (s_sel_q[i]) begin
          shadow_d[4*i +: 4] = seg_nib;
        end
      end
      seen_d = seen_d | s_sel_q;
    end
  end

  // Sticky errors: a fresh error on the clearing edge takes priority.
  always_comb begin
    err_pat_d = err_clr ? 1'b0 : err_pat_q;
    err_sel_d = err_clr ? 1'b0 : err_sel_q;
    if (capture && sel_onehot && !seg_legal) begin
      err_pat_d = 1'b1;
    end
    if (capture && sel_multi) begin
      err_sel_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_WAIT;
      s_sel_q     <= '0;
      s_seg_q     <= C_BLANK;
      cnt_q       <= 8'd0;
      seen_q      <= '0;
      shadow_q    <= '0;
      dig_val_q   <= '0;
      frame_vld_q <= 1'b0;
      err_pat_q   <= 1'b0;
      err_sel_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_sel_q     <= s_sel_d;
      s_seg_q     <= s_seg_d;
      cnt_q       <= cnt_d;
      seen_q      <= seen_d;
      shadow_q    <= shadow_d;
      dig_val_q   <= dig_val_d;
      frame_vld_q <= frame_vld_d;
      err_pat_q   <= err_pat_d;
      err_sel_q   <= err_sel_d;
    end
  end

  assign dig_val   = dig_val_q;
  assign frame_vld = frame_vld_q;
  assign err_pat   = err_pat_q;
  assign err_sel   = err_sel_q;

endmodule
`default_nettype wire

// File: tb/tb_sev_seg_capture.sv
`default_nettype none
// tb_sev_seg_capture: directed + randomized scan sequences, frames checked by
// a queue-based scoreboard fed from an abstract digit/hold-time model.
module tb_sev_seg_capture;

  localparam int NUM_DIG    = 6;
  localparam int STABLE_CYC = 4;
  localparam int W          = 4 * NUM_DIG;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NUM_DIG-1:0] dig_sel;
  logic [6:0]         ss_val;
  logic               err_clr;
  logic [W-1:0]       dig_val;
  logic               frame_vld;
  logic               err_pat;
  logic               err_sel;

  always #5 clk = ~clk;

  sev_seg_capture #(
    .NUM_DIG   (NUM_DIG),
    .STABLE_CYC(STABLE_CYC)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .dig_sel  (dig_sel),
    .ss_val   (ss_val),
    .err_clr  (err_clr),
    .dig_val  (dig_val),
    .frame_vld(frame_vld),
    .err_pat  (err_pat),
    .err_sel  (err_sel)
  );

  int           total = 0;
  int           bad   = 0;
  int           frames_pushed = 0;
  int           frames_seen   = 0;
  logic [W-1:0] exp_q[$];

  logic [6:0]   glyph [16];
  logic [3:0]   m_shadow [NUM_DIG];
  logic [NUM_DIG-1:0] m_seen;
  logic         m_err_pat;
  logic         m_err_sel;
  logic [NUM_DIG-1:0] prev_sel;
  logic [6:0]   prev_seg;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int decode(input logic [6:0] seg);
    for (int v = 0; v < 16; v++) begin
      if (glyph[v] == seg) return v;
    end
    return -1;
  endfunction

  function automatic logic [NUM_DIG-1:0] onehot(input int i);
    logic [NUM_DIG-1:0] r;
    r    = '0;
    r[i] = 1'b1;
    return r;
  endfunction

  function automatic logic [W-1:0] model_frame();
    logic [W-1:0] f;
    for (int i = 0; i < NUM_DIG; i++) f[4*i +: 4] = m_shadow[i];
    return f;
  endfunction

  // Abstract effect of a pattern that has been stable long enough.
  task automatic model_capture(input logic [NUM_DIG-1:0] sel, input logic [6:0] seg);
    int n;
    int v;
    n = $countones(sel);
    v = decode(seg);
    if (n == 1) begin
      if (v < 0) begin
        m_err_pat = 1'b1;
      end else begin
        for (int i = 0; i < NUM_DIG; i++) begin
          if (sel[i]) begin
            m_shadow[i] = v[3:0];
            m_seen[i]   = 1'b1;
          end
        end
        if (&m_seen) begin
          exp_q.push_back(model_frame());
          frames_pushed++;
          m_seen = '0;
        end
      end
    end else if (n > 1) begin
      m_err_sel = 1'b1;
    end
  endtask

  task automatic model_reset();
    m_seen    = '0;
    m_err_pat = 1'b0;
    m_err_sel = 1'b0;
    for (int i = 0; i < NUM_DIG; i++) m_shadow[i] = 4'h0;
    prev_sel = '0;
    prev_seg = 7'h7F;
  endtask

  // Present one pattern for 'hold' rising edges; err_clr is high for edge clr_at.
  task automatic item(input logic [NUM_DIG-1:0] sel, input logic [6:0] seg,
                      input int hold, input int clr_at);
    @(negedge clk);
    dig_sel = sel;
    ss_val  = seg;
    for (int e = 1; e <= hold; e++) begin
      err_clr = (e == clr_at);
      @(posedge clk);
      #1;
      if (e == clr_at) begin
        m_err_pat = 1'b0;
        m_err_sel = 1'b0;
      end
      if (e == STABLE_CYC + 1) model_capture(sel, seg);
    end
    err_clr  = 1'b0;
    prev_sel = sel;
    prev_seg = seg;
    check("err_pat", err_pat, m_err_pat);
    check("err_sel", err_sel, m_err_sel);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n   = 1'b0;
    dig_sel = '0;
    ss_val  = 7'h7F;
    err_clr = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    check("reset err_pat", err_pat, 0);
    check("reset err_sel", err_sel, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic scan(input int v0, input int v1, input int v2,
                      input int v3, input int v4, input int v5, input int hold);
    int vals[6];
    vals = '{v0, v1, v2, v3, v4, v5};
    for (int i = 0; i < NUM_DIG; i++) item(onehot(i), glyph[vals[i]], hold, 0);
  endtask

  // Monitor: pops an expected frame on every frame_vld and checks dig_val holds.
  initial begin
    logic         prev_vld;
    logic [W-1:0] last;
    logic [W-1:0] e;
    prev_vld = 1'b0;
    last     = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        check("reset dig_val", dig_val, 0);
        check("reset frame_vld", frame_vld, 0);
        last     = '0;
        prev_vld = 1'b0;
      end else begin
        if (frame_vld) begin
          frames_seen++;
          check("frame_vld width", prev_vld, 0);
          if (exp_q.size() == 0) begin
            check("unexpected frame_vld", frame_vld, 0);
          end else begin
            e = exp_q.pop_front();
            check("frame dig_val", dig_val, e);
            last = e;
          end
        end else begin
          check("dig_val hold", dig_val, last);
        end
        prev_vld = frame_vld;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, frames seen %0d expected %0d",
             frames_seen, frames_pushed);
    $fatal(1);
  end

  initial begin
    logic [NUM_DIG-1:0] sel;
    logic [6:0]         seg;
    int                 r;
    int                 hold;
    int                 clr;

    glyph = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    rst_n   = 1'b0;
    dig_sel = '0;
    ss_val  = 7'h7F;
    err_clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("init err_pat", err_pat, 0);
    check("init err_sel", err_sel, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Plain full frame.
    scan(1, 2, 3, 4, 5, 9, 6);
    item('0, 7'h7F, 3, 0);
    check("frame 954321", dig_val, 24'h954321);

    // Stability boundary on digit 0: 4 edges rejected, 5 edges accepted.
    for (int i = 1; i < NUM_DIG; i++) item(onehot(i), glyph[i + 6], 6, 0);
    item(onehot(0), glyph[7], STABLE_CYC, 0);
    item('0, 7'h7F, 2, 0);
    item(onehot(0), glyph[8], STABLE_CYC + 1, 0);
    item('0, 7'h7F, 3, 0);

    // Illegal glyph then clear; digit 0 must still be missing afterwards.
    item(onehot(0), 7'h7F, 6, 0);
    item('0, 7'h7F, 2, 1);
    for (int i = 1; i < NUM_DIG; i++) item(onehot(i), glyph[15 - i], 6, 0);
    item(onehot(0), glyph[3], 6, 0);

    // Multi-hot, then a clear landing on the edge of a new multi-hot capture.
    item(6'b000011, glyph[0], 6, 0);
    item('0, 7'h7F, 2, 0);
    item(6'b000011, glyph[1], 6, STABLE_CYC + 1);
    item('0, 7'h7F, 2, 1);

    // Reset mid-frame discards partial captures.
    for (int i = 0; i < 3; i++) item(onehot(i), glyph[i + 10], 6, 0);
    do_reset();
    scan(6, 7, 8, 9, 10, 11, 6);
    item('0, 7'h7F, 3, 0);

    // Glyph sweep on digit 0 with fixed other digits.
    for (int v = 0; v < 16; v++) scan(v, 12, 13, 14, 0, 5, 6);

    // Randomized scans, blanks, illegal glyphs, multi-hot and short holds.
    for (int n = 0; n < 300; n++) begin
      do begin
        r = $urandom_range(0, 99);
        if (r < 60) begin
          sel = onehot($urandom_range(0, NUM_DIG - 1));
          seg = glyph[$urandom_range(0, 15)];
        end else if (r < 72) begin
          sel = '0;
          seg = 7'($urandom_range(0, 127));
        end else if (r < 84) begin
          sel = onehot($urandom_range(0, NUM_DIG - 1));
          do seg = 7'($urandom_range(0, 127)); while (decode(seg) >= 0);
        end else begin
          do sel = NUM_DIG'($urandom_range(0, (1 << NUM_DIG) - 1));
          while ($countones(sel) < 2);
          seg = glyph[$urandom_range(0, 15)];
        end
      end while (sel == prev_sel && seg == prev_seg);
      hold = $urandom_range(1, 8);
      clr  = ($urandom_range(0, 9) == 0) ? $urandom_range(1, hold) : 0;
      item(sel, seg, hold, clr);
    end

    repeat (4) @(posedge clk);
    #1;
    check("frame count", frames_seen, frames_pushed);
    check("scoreboard drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
